// File: rtl/mux_rr_n_1.sv
// N-channel registered multiplexer with valid/ready handshakes on every port.
// Channel choice is either a fixed select or fair round-robin arbitration.
module mux_rr_n_1 #(
   parameter  int WIDTH = 4,
   parameter  int NCH   = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NCH*WIDTH-1:0] in_data_i,
   input  logic [NCH-1:0]       in_valid_i,
   output logic [NCH-1:0]       in_ready_o,
   input  logic                 mode_i,
   input  logic [SELW-1:0]      sel_i,
   output logic [WIDTH-1:0]     out_data_o,
   output logic [SELW-1:0]      out_ch_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);

   logic [WIDTH-1:0] outData_q, outData_d;
   logic [SELW-1:0]  outCh_q, outCh_d;
   logic             outValid_q, outValid_d;
   logic [SELW-1:0]  rrPtr_q, rrPtr_d;

   logic [NCH-1:0]   grant;
   logic [NCH-1:0]   inReady;
   logic             loadEn;
   logic             transfer;
   logic [WIDTH-1:0] selData;
   logic [SELW-1:0]  selCh;

   // Round-robin search starts one past the last granted channel and wraps.
   always_comb begin
      int  idx;
      logic found;
      grant = '0;
      idx   = 0;
      found = 1'b0;
      if (!mode_i) begin
         if (int'(sel_i) < NCH) begin
            grant[sel_i] = in_valid_i[sel_i];
         end
      end else begin
         for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rrPtr_q) + k) % NCH;
            if (!found && in_valid_i[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

   always_comb begin
      selData = '0;
      selCh   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            selData = in_data_i[i*WIDTH +: WIDTH];
            selCh   = SELW'(i);
         end
      end
   end

   assign loadEn     = !outValid_q || out_ready_i;
   assign inReady    = rst_ni ? (grant & {NCH{loadEn}}) : '0;
   assign transfer   = |inReady;
   assign in_ready_o = inReady;

   always_comb begin
      outData_d  = outData_q;
      outCh_d    = outCh_q;
      outValid_d = outValid_q;
      rrPtr_d    = rrPtr_q;
      if (transfer) begin
         outData_d  = selData;
         outCh_d    = selCh;
         outValid_d = 1'b1;
         if (mode_i) begin
            rrPtr_d = selCh;
         end
      end else if (out_ready_i) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outData_q  <= '0;
         outCh_q    <= '0;
         outValid_q <= 1'b0;
         rrPtr_q    <= SELW'(NCH - 1);
      end else begin
         outData_q  <= outData_d;
         outCh_q    <= outCh_d;
         outValid_q <= outValid_d;
         rrPtr_q    <= rrPtr_d;
      end
   end

   assign out_data_o  = outData_q;
   assign out_ch_o    = outCh_q;
   assign out_valid_o = outValid_q;

endmodule

// File: tb/tb_mux_rr_n_1.sv
// Bench for mux_rr_n_1: directed vector table, async reset checks and a
// randomized phase against a behavioural model of the arbitration rules.
module tb_mux_rr_n_1;

   localparam int WIDTH = 4;
   localparam int NCH   = 4;

   logic                 clk;
   logic                 rstN;
   logic [NCH*WIDTH-1:0] inData;
   logic [NCH-1:0]       inValid;
   logic [NCH-1:0]       inReady;
   logic                 mode;
   logic [1:0]           sel;
   logic [WIDTH-1:0]     outData;
   logic [1:0]           outCh;
   logic                 outValid;
   logic                 outReady;

   // Second instance with three channels, used only for the out-of-range select.
   logic [3*WIDTH-1:0]   inData3;
   logic [2:0]           inValid3;
   logic [2:0]           inReady3;
   logic [1:0]           sel3;
   logic [WIDTH-1:0]     outData3;
   logic [1:0]           outCh3;
   logic                 outValid3;

   int testsRun;
   int testsFailed;

   int mValid;
   int mData;
   int mCh;
   int mPtr;

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic [3:0] valid;
      logic       oReady;
      logic [3:0] expReady;
      logic       expValid;
      logic [1:0] expCh;
      logic [3:0] expData;
   } vector_t;

   vector_t vecs[19];

   mux_rr_n_1 #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .in_data_i   (inData),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady),
      .mode_i      (mode),
      .sel_i       (sel),
      .out_data_o  (outData),
      .out_ch_o    (outCh),
      .out_valid_o (outValid),
      .out_ready_i (outReady)
   );

   mux_rr_n_1 #(.WIDTH(WIDTH), .NCH(3)) dut3 (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .in_data_i   (inData3),
      .in_valid_i  (inValid3),
      .in_ready_o  (inReady3),
      .mode_i      (1'b0),
      .sel_i       (sel3),
      .out_data_o  (outData3),
      .out_ch_o    (outCh3),
      .out_valid_o (outValid3),
      .out_ready_i (1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Which channel the rules say should be accepted right now (-1 for none).
   function automatic int modelPick();
      int loadEn;
      loadEn = (mValid == 0 || outReady) ? 1 : 0;
      if (!rstN || loadEn == 0) return -1;
      if (mode == 1'b0) begin
         if (int'(sel) < NCH && inValid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (mPtr + k) % NCH;
         if (inValid[c]) return c;
      end
      return -1;
   endfunction

   function automatic int modelReady();
      int p;
      p = modelPick();
      return (p < 0) ? 0 : (1 << p);
   endfunction

   task automatic modelReset();
      mValid = 0;
      mData  = 0;
      mCh    = 0;
      mPtr   = NCH - 1;
   endtask

   task automatic modelEdge(input int pick);
      if (pick >= 0) begin
         mValid = 1;
         mData  = int'(inData[pick*WIDTH +: WIDTH]);
         mCh    = pick;
         if (mode) mPtr = pick;
      end else if (outReady) begin
         mValid = 0;
      end
   endtask

   // Called just after a rising edge with inputs already applied.
   task automatic applyStimulus(input string tag);
      int pick;
      @(negedge clk);
      checkOutput({tag, ".in_ready"}, int'(inReady), modelReady());
      pick = modelPick();
      @(posedge clk);
      modelEdge(pick);
      #1;
      checkOutput({tag, ".out_valid"}, int'(outValid), mValid);
      if (mValid != 0) begin
         checkOutput({tag, ".out_data"}, int'(outData), mData);
         checkOutput({tag, ".out_ch"}, int'(outCh), mCh);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      modelReset();

      // ch0=A ch1=B ch2=C ch3=D
      inData   = 16'hDCBA;
      inValid  = 4'b1111;
      mode     = 1'b1;
      sel      = 2'd0;
      outReady = 1'b1;
      inData3  = 12'h987;
      inValid3 = 3'b111;
      sel3     = 2'd3;
      rstN     = 1'b0;

      vecs[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
      vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
      vecs[8]  = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      vecs[9]  = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      vecs[10] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      vecs[11] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      vecs[12] = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 4'hC};
      vecs[13] = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 4'hC};
      vecs[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 4'hC};
      vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC};
      vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC};
      vecs[17] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC};
      vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};

      // Reset held with every channel requesting.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.out_valid", int'(outValid), 0);
      checkOutput("reset.out_data", int'(outData), 0);
      checkOutput("reset.out_ch", int'(outCh), 0);
      checkOutput("reset.in_ready", int'(inReady), 0);
      rstN = 1'b1;

      // Directed table, each row checked against its hand-written result and the model.
      for (int v = 0; v < 19; v++) begin
         int pick;
         mode     = vecs[v].mode;
         sel      = vecs[v].sel;
         inValid  = vecs[v].valid;
         outReady = vecs[v].oReady;
         @(negedge clk);
         checkOutput($sformatf("vec%0d.in_ready", v), int'(inReady), int'(vecs[v].expReady));
         checkOutput($sformatf("vec%0d.in_ready_model", v), int'(inReady), modelReady());
         pick = modelPick();
         @(posedge clk);
         modelEdge(pick);
         #1;
         checkOutput($sformatf("vec%0d.out_valid", v), int'(outValid), int'(vecs[v].expValid));
         checkOutput($sformatf("vec%0d.out_ch", v), int'(outCh), int'(vecs[v].expCh));
         checkOutput($sformatf("vec%0d.out_data", v), int'(outData), int'(vecs[v].expData));
      end

      // Three-channel instance with sel=3 never grants.
      checkOutput("nch3.in_ready", int'(inReady3), 0);
      checkOutput("nch3.out_valid", int'(outValid3), 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         inData   = 16'($urandom);
         inValid  = 4'($urandom);
         mode     = 1'($urandom);
         sel      = 2'($urandom);
         outReady = ($urandom_range(0, 3) != 0);
         applyStimulus($sformatf("rand%0d", n));
      end

      // Fill the output register, then reset between edges.
      mode     = 1'b1;
      inValid  = 4'b1111;
      outReady = 1'b0;
      applyStimulus("prefill");
      checkOutput("prefill.out_valid_set", int'(outValid), 1);
      #2;
      rstN = 1'b0;
      modelReset();
      #1;
      checkOutput("async.out_valid", int'(outValid), 0);
      checkOutput("async.out_data", int'(outData), 0);
      checkOutput("async.in_ready", int'(inReady), 0);
      @(posedge clk);
      #1;
      rstN     = 1'b1;
      outReady = 1'b1;
      applyStimulus("postreset");
      checkOutput("postreset.first_ch", int'(outCh), 0);
      checkOutput("nch3.final_out_valid", int'(outValid3), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
